// File: rtl/pc_stack_unit.sv
// Program counter with increment, absolute load, relative branch and call/return.
// Latency: one cycle. Every output is registered, and an operation sampled at edge N is visible after edge N.
// Backpressure: none. When en=0 the unit holds its state, but clr_err is still honoured.
module pc_stack_unit #(
    parameter int                ADDR_W      = 10,
    parameter int                DISP_W      = 8,
    parameter int                STACK_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           en,
    input  logic                           ld,
    input  logic                           br,
    input  logic                           call,
    input  logic                           ret,
    input  logic                           clr_err,
    input  logic [ADDR_W-1:0]              target,
    input  logic [DISP_W-1:0]              disp,
    output logic [ADDR_W-1:0]              pc,
    output logic [ADDR_W-1:0]              top,
    output logic [$clog2(STACK_DEPTH):0]   depth,
    output logic                           ovf,
    output logic                           unf
);
    localparam int PW = $clog2(STACK_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(STACK_DEPTH);

    // The return stack is circular. wptr points at the next free slot.
    // When the stack is full, wptr also points at the oldest entry,
    // so a push overwrites the oldest entry with no extra logic.
    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     wptr_nxt;
    logic [PW:0]       depth_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] top_nxt;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] below_top;
    logic [ADDR_W-1:0] disp_ext;
    logic              push;
    logic              set_ovf;
    logic              set_unf;

    assign pc_inc    = pc + ADDR_W'(1);
    assign disp_ext  = ADDR_W'($signed(disp));
    // This is the entry under the current head. It becomes the new head after a pop.
    assign below_top = mem[wptr - PW'(2)];

    // Select one action per cycle. The priority is ret > call > ld > br > increment.
    always_comb begin
        pc_nxt    = pc;
        top_nxt   = top;
        depth_nxt = depth;
        wptr_nxt  = wptr;
        push      = 1'b0;
        set_ovf   = 1'b0;
        set_unf   = 1'b0;
        if (en) begin
            if (ret) begin
                if (depth == '0) begin
                    // A ret on an empty stack behaves like an increment and flags the error.
                    set_unf = 1'b1;
                    pc_nxt  = pc_inc;
                end else begin
                    pc_nxt    = top;
                    wptr_nxt  = wptr - PW'(1);
                    depth_nxt = depth - (PW+1)'(1);
                    top_nxt   = (depth == (PW+1)'(1)) ? '0 : below_top;
                end
            end else if (call) begin
                push     = 1'b1;
                pc_nxt   = target;
                wptr_nxt = wptr + PW'(1);
                top_nxt  = pc_inc;
                if (depth == FULL) begin
                    set_ovf = 1'b1;
                end else begin
                    depth_nxt = depth + (PW+1)'(1);
                end
            end else if (ld) begin
                pc_nxt = target;
            end else if (br) begin
                pc_nxt = pc + disp_ext;
            end else begin
                pc_nxt = pc_inc;
            end
        end
    end

    // Control state and sticky flags. If clr_err arrives in the same cycle as a new error, the new error wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= RESET_PC;
            top   <= '0;
            depth <= '0;
            wptr  <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            pc    <= pc_nxt;
            top   <= top_nxt;
            depth <= depth_nxt;
            wptr  <= wptr_nxt;
            ovf   <= (ovf & ~clr_err) | set_ovf;
            unf   <= (unf & ~clr_err) | set_unf;
        end
    end

    // Stack storage. Its contents are don't-care after reset, so the array itself is not reset.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wptr] <= pc_inc;
        end
    end
endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed testbench for pc_stack_unit with the default parameters (ADDR_W=10, STACK_DEPTH=8).
// Inputs are driven after a clock edge, and outputs are sampled 1ns after the edge.
// The bench prints a single summary line at the end of the run.
module tb_pc_stack_unit;
    logic       clk = 1'b0;
    logic       reset, en, ld, br, call, ret, clr_err;
    logic [9:0] target;
    logic [7:0] disp;
    logic [9:0] pc, top;
    logic [3:0] depth;
    logic       ovf, unf;

    int checks   = 0;
    int failures = 0;

    pc_stack_unit dut (
        .clk(clk), .reset(reset), .en(en), .ld(ld), .br(br), .call(call), .ret(ret),
        .clr_err(clr_err), .target(target), .disp(disp),
        .pc(pc), .top(top), .depth(depth), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ld = 0; br = 0; call = 0; ret = 0; clr_err = 0;
    endtask

    task automatic do_call(input logic [9:0] t);
        idle(); call = 1; target = t; tick(); idle();
    endtask

    task automatic do_ld(input logic [9:0] t);
        idle(); ld = 1; target = t; tick(); idle();
    endtask

    task automatic test_reset();
        reset = 1; en = 0; idle(); target = 0; disp = 0;
        tick(); tick();
        reset = 0;
        checks++; if (pc !== 10'h000) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 10'h000); end
        checks++; if (depth !== 4'd0) begin failures++; $display("FAIL reset_depth got=%0d exp=0", depth); end
        checks++; if (top !== 10'h000) begin failures++; $display("FAIL reset_top got=%h exp=000", top); end
        checks++; if ({ovf, unf} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {ovf, unf}); end
        en = 1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++; if (pc !== 10'(i)) begin failures++; $display("FAIL incr_pc%0d got=%h exp=%h", i, pc, 10'(i)); end
        end
        checks++; if (depth !== 4'd0 || ovf !== 1'b0 || unf !== 1'b0) begin
            failures++; $display("FAIL incr_state got depth=%0d ovf=%b unf=%b exp 0/0/0", depth, ovf, unf);
        end
    endtask

    task automatic test_wrap_branch();
        en = 1;
        do_ld(10'h3FF);
        checks++; if (pc !== 10'h3FF) begin failures++; $display("FAIL ld_pc got=%h exp=3ff", pc); end
        tick();
        checks++; if (pc !== 10'h000) begin failures++; $display("FAIL wrap_pc got=%h exp=000", pc); end
        do_ld(10'h010);
        br = 1; disp = 8'hF0; tick(); idle();
        checks++; if (pc !== 10'h000) begin failures++; $display("FAIL br_neg got=%h exp=000", pc); end
        br = 1; disp = 8'h00; tick(); idle();
        checks++; if (pc !== 10'h000) begin failures++; $display("FAIL br_zero got=%h exp=000", pc); end
        br = 1; disp = 8'h7F; tick(); idle();
        checks++; if (pc !== 10'h07F) begin failures++; $display("FAIL br_pos got=%h exp=07f", pc); end
        br = 1; disp = 8'h80; tick(); idle();
        checks++; if (pc !== 10'h3FF) begin failures++; $display("FAIL br_wrap got=%h exp=3ff", pc); end
        ld = 1; br = 1; target = 10'h200; disp = 8'h05; tick(); idle();
        checks++; if (pc !== 10'h200) begin failures++; $display("FAIL ld_over_br got=%h exp=200", pc); end
    endtask

    task automatic test_call_ret();
        en = 1;
        do_ld(10'h020);
        do_call(10'h100);
        checks++; if (pc !== 10'h100) begin failures++; $display("FAIL call_pc got=%h exp=100", pc); end
        checks++; if (top !== 10'h021) begin failures++; $display("FAIL call_top got=%h exp=021", top); end
        checks++; if (depth !== 4'd1) begin failures++; $display("FAIL call_depth got=%0d exp=1", depth); end
        ret = 1; tick(); idle();
        checks++; if (pc !== 10'h021) begin failures++; $display("FAIL ret_pc got=%h exp=021", pc); end
        checks++; if (depth !== 4'd0 || top !== 10'h000) begin
            failures++; $display("FAIL ret_stack got depth=%0d top=%h exp 0/000", depth, top);
        end
    endtask

    task automatic test_overflow_underflow();
        logic [9:0] link [9];
        en = 1;
        do_ld(10'h200);
        // Call i jumps to 0x100+16*i. The link it pushes is (pc before the call)+1.
        for (int i = 0; i < 9; i++) begin
            link[i] = (i == 0) ? 10'h201 : 10'(32'h101 + (i - 1) * 16);
            do_call(10'(32'h100 + i * 16));
            checks++; if (top !== link[i] || depth !== 4'((i < 8) ? i + 1 : 8)) begin
                failures++; $display("FAIL call%0d got top=%h depth=%0d exp top=%h depth=%0d",
                                     i, top, depth, link[i], (i < 8) ? i + 1 : 8);
            end
        end
        checks++; if (ovf !== 1'b1 || unf !== 1'b0) begin failures++; $display("FAIL ovf_set got ovf=%b unf=%b exp 1/0", ovf, unf); end
        for (int k = 0; k < 8; k++) begin
            ret = 1; tick(); idle();
            checks++; if (pc !== link[8-k] || depth !== 4'(7 - k) || top !== ((k < 7) ? link[7-k] : 10'h000)) begin
                failures++; $display("FAIL ret%0d got pc=%h depth=%0d top=%h exp pc=%h depth=%0d top=%h",
                                     k, pc, depth, top, link[8-k], 7 - k, (k < 7) ? link[7-k] : 10'h000);
            end
        end
        ret = 1; tick(); idle();
        checks++; if (pc !== 10'h102 || depth !== 4'd0 || unf !== 1'b1) begin
            failures++; $display("FAIL unf_ret got pc=%h depth=%0d unf=%b exp 102/0/1", pc, depth, unf);
        end
        en = 0; clr_err = 1; tick(); idle();
        checks++; if (ovf !== 1'b0 || unf !== 1'b0 || pc !== 10'h102) begin
            failures++; $display("FAIL clr_err_en0 got ovf=%b unf=%b pc=%h exp 0/0/102", ovf, unf, pc);
        end
        en = 1;
    endtask

    task automatic test_priority_hold();
        en = 1;
        do_ld(10'h030);
        do_call(10'h054);
        do_call(10'h070);
        checks++; if (depth !== 4'd2 || top !== 10'h055) begin failures++; $display("FAIL prio_setup got depth=%0d top=%h exp 2/055", depth, top); end
        call = 1; ret = 1; ld = 1; target = 10'h3AA; tick(); idle();
        checks++; if (pc !== 10'h055 || depth !== 4'd1 || top !== 10'h031) begin
            failures++; $display("FAIL ret_wins got pc=%h depth=%0d top=%h exp 055/1/031", pc, depth, top);
        end
        checks++; if (ovf !== 1'b0 || unf !== 1'b0) begin failures++; $display("FAIL ret_wins_flags got %b%b exp 00", ovf, unf); end
        en = 0; ld = 1; target = 10'h123; tick(); idle();
        checks++; if (pc !== 10'h055) begin failures++; $display("FAIL hold_ld got=%h exp=055", pc); end
        call = 1; target = 10'h123; tick(); idle();
        checks++; if (pc !== 10'h055 || depth !== 4'd1 || top !== 10'h031) begin
            failures++; $display("FAIL hold_call got pc=%h depth=%0d top=%h exp 055/1/031", pc, depth, top);
        end
        en = 1;
    endtask

    task automatic test_mid_reset();
        en = 1;
        for (int i = 0; i < 9; i++) do_call(10'(32'h300 + i));
        for (int k = 0; k < 5; k++) begin ret = 1; tick(); idle(); end
        checks++; if (depth !== 4'd3 || ovf !== 1'b1) begin failures++; $display("FAIL pre_reset got depth=%0d ovf=%b exp 3/1", depth, ovf); end
        reset = 1; call = 1; target = 10'h2AA; tick(); reset = 0; idle();
        checks++; if (pc !== 10'h000 || depth !== 4'd0 || top !== 10'h000 || ovf !== 1'b0 || unf !== 1'b0) begin
            failures++; $display("FAIL mid_reset got pc=%h depth=%0d top=%h ovf=%b unf=%b exp 000/0/000/0/0", pc, depth, top, ovf, unf);
        end
        ret = 1; clr_err = 1; tick(); idle();
        checks++; if (unf !== 1'b1 || pc !== 10'h001 || depth !== 4'd0) begin
            failures++; $display("FAIL clr_vs_unf got unf=%b pc=%h depth=%0d exp 1/001/0", unf, pc, depth);
        end
    endtask

    initial begin
        test_reset();
        test_wrap_branch();
        test_call_ret();
        test_overflow_underflow();
        test_priority_hold();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
